// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_pkg                                                    |
// | Brief   : Shared types, constants and parity helper for the UART TX.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_W_MAX    = 9;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    EVEN  = 3'd1,
    ODD   = 3'd2,
    MARK  = 3'd3,
    SPACE = 3'd4
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  // Parity covers only the low n bits that actually go on the wire.
  function automatic logic parity_calc(input logic [DATA_W_MAX-1:0] data,
                                       input logic [3:0] n,
                                       input parity_e mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (i < int'(n)) x = x ^ data[i];
    end
    case (mode)
      EVEN:    return x;
      ODD:     return ~x;
      MARK:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_sync_fifo                                              |
// | Brief   : Single-clock FIFO with flush; read data from register array.|
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO refuses writes even when a pop frees a slot this cycle.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                                |
// | Brief   : UART transmitter with TX FIFO and runtime frame format.     |
// |           Define UART_TX_CTS_EN to add the cts_n flow-control input.  |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BAUD_W-1:0]             baud_div,
  input  logic [3:0]                    data_bits,
  input  logic [2:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx_done,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          uart_txd
);

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full, fifo_empty, pop, start_ok;
  logic [3:0]            cfg_n;
  parity_e               cfg_mode;
  logic [BAUD_W-1:0]     cfg_baud;

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     cnt_q, cnt_d, baud_q, baud_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]            nbits_q, nbits_d, bit_cnt_q, bit_cnt_d;
  logic                  has_par_q, has_par_d, par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d, txd_q, txd_d, tx_done_q, tx_done_d;
  logic                  last;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data (tx_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

`ifdef UART_TX_CTS_EN
  logic cts_s1_q, cts_s1_d, cts_s2_q, cts_s2_d;

  always_comb begin
    cts_s1_d = cts_n;
    cts_s2_d = cts_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_s1_d;
      cts_s2_q <= cts_s2_d;
    end
  end

  assign start_ok = !cts_s2_q;
`else
  assign start_ok = 1'b1;
`endif

  assign tx_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx_done  = tx_done_q;
  assign uart_txd = txd_q;

  always_comb begin
    cfg_n    = (data_bits < 4'(DATA_BITS_MIN) || data_bits > 4'(DATA_WIDTH))
               ? 4'(DATA_WIDTH) : data_bits;
    cfg_mode = (parity_mode > 3'd4) ? NONE : parity_e'(parity_mode);
    cfg_baud = (baud_div == '0) ? BAUD_W'(1) : baud_div;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    baud_d    = baud_q;
    shreg_d   = shreg_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    has_par_d = has_par_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    last      = (cnt_q == '0);
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        // Whole frame format is captured here so later config writes cannot tear a frame.
        if (!fifo_empty && start_ok) begin
          pop       = 1'b1;
          state_d   = START;
          txd_d     = 1'b0;
          cnt_d     = cfg_baud - BAUD_W'(1);
          baud_d    = cfg_baud;
          shreg_d   = fifo_rd_data;
          nbits_d   = cfg_n;
          bit_cnt_d = '0;
          has_par_d = (cfg_mode != NONE);
          par_bit_d = parity_calc(DATA_W_MAX'(fifo_rd_data), cfg_n, cfg_mode);
          stop2_d   = stop_bits;
        end
      end
      default: begin
        if (!last) begin
          cnt_d = cnt_q - BAUD_W'(1);
        end else begin
          cnt_d = baud_q - BAUD_W'(1);
          case (state_q)
            START: begin
              state_d = DATA;
              txd_d   = shreg_q[0];
            end
            DATA: begin
              if (bit_cnt_q == nbits_q - 4'd1) begin
                state_d = has_par_q ? PARITY : STOP1;
                txd_d   = has_par_q ? par_bit_q : 1'b1;
              end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shreg_d   = shreg_q >> 1;
                txd_d     = shreg_q[1];
              end
            end
            PARITY: begin
              state_d = STOP1;
              txd_d   = 1'b1;
            end
            STOP1: begin
              state_d = stop2_q ? STOP2 : IDLE;
              txd_d   = 1'b1;
            end
            default: begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          endcase
        end
      end
    endcase
    tx_done_d = (cnt_d == '0) &&
                ((state_d == STOP1 && !stop2_d) || state_d == STOP2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      baud_q    <= BAUD_W'(1);
      shreg_q   <= '0;
      nbits_q   <= 4'(DATA_WIDTH);
      bit_cnt_q <= '0;
      has_par_q <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      baud_q    <= baud_d;
      shreg_q   <= shreg_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      has_par_q <= has_par_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_uart_tx_fifo                                             |
// | Brief   : Directed, table-driven bench for uart_tx_fifo.              |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic [2:0]  parity_mode;
  logic        stop_bits;
  logic        flush;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        tx_done;
  logic        uart_txd;
`ifdef UART_TX_CTS_EN
  logic        cts_n = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .BAUD_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop_bits   (stop_bits),
    .flush       (flush),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .tx_done     (tx_done),
`ifdef UART_TX_CTS_EN
    .cts_n       (cts_n),
`endif
    .uart_txd    (uart_txd)
  );

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  n_in;
    logic [2:0]  mode;
    logic        stop;
    logic [15:0] baud;
    int          exp_n;
    int          exp_baud;
    bit          exp_has_par;
    bit          exp_par;
    int          exp_bits;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int n, input bit hp,
                                   input bit p, input int c, input int b);
    int idx;
    idx = c / b;
    if (idx == 0) return 1'b0;
    if (idx <= n) return d[idx-1];
    if (hp && idx == n + 1) return p;
    return 1'b1;
  endfunction

  function automatic logic [7:0] word(input int w);
    return 8'(w * 37 + 5);
  endfunction

  task automatic set_8n1(input logic [15:0] b);
    baud_div = b; data_bits = 4'd8; parity_mode = 3'd0; stop_bits = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int total;
    @(negedge clk);
    baud_div = v.baud; data_bits = v.n_in; parity_mode = v.mode;
    stop_bits = v.stop; tx_data = v.data; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, " level after push"}, 32'(fifo_level), 32'd1);
    check({tag, " txd before start"}, 32'(uart_txd), 32'd1);
    total = v.exp_bits * v.exp_baud;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (c == 0) begin
        baud_div = 16'd7; data_bits = 4'd5; parity_mode = 3'd2;
        stop_bits = ~v.stop; tx_data = ~v.data;
      end
      check($sformatf("%s txd c%0d", tag, c), 32'(uart_txd),
            32'(exp_bit(v.data, v.exp_n, v.exp_has_par, v.exp_par, c, v.exp_baud)));
      check($sformatf("%s tx_done c%0d", tag, c), 32'(tx_done), 32'(c == total - 1));
    end
    @(negedge clk);
    check({tag, " idle txd"}, 32'(uart_txd), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle tx_done"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 4'd8, 3'd0, 1'b0, 16'd4, 8, 4, 1'b0, 1'b0, 10};
    vecs[1] = '{8'h55, 4'd7, 3'd1, 1'b1, 16'd3, 7, 3, 1'b1, 1'b0, 11};
    vecs[2] = '{8'h80, 4'd8, 3'd2, 1'b0, 16'd2, 8, 2, 1'b1, 1'b0, 11};
    vecs[3] = '{8'h1F, 4'd5, 3'd3, 1'b0, 16'd2, 5, 2, 1'b1, 1'b1, 8};
    vecs[4] = '{8'h3F, 4'd6, 3'd4, 1'b0, 16'd2, 6, 2, 1'b1, 1'b0, 9};
    vecs[5] = '{8'hE3, 4'd3, 3'd1, 1'b0, 16'd0, 8, 1, 1'b1, 1'b1, 11};
    vecs[6] = '{8'hC6, 4'd9, 3'd6, 1'b1, 16'd1, 8, 1, 1'b0, 1'b0, 11};
    vecs[7] = '{8'hFA, 4'd5, 3'd2, 1'b1, 16'd3, 5, 3, 1'b1, 1'b0, 9};

    rst_n = 1'b0; flush = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    set_8n1(16'd4);
    repeat (3) @(negedge clk);
    check("reset txd", 32'(uart_txd), 32'd1);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset level", 32'(fifo_level), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Burst of 18 writes at baud 2: 17 accepted, back-to-back frames with one idle cycle.
    set_8n1(16'd2);
    for (int g = 0; g < 359; g++) begin
      @(negedge clk);
      if (g >= 2) begin
        int t, k, c;
        t = g - 2; k = t / 21; c = t % 21;
        if (c < 20) begin
          check($sformatf("burst f%0d txd c%0d", k, c), 32'(uart_txd),
                32'(exp_bit(word(k), 8, 1'b0, 1'b0, c, 2)));
          check($sformatf("burst f%0d tx_done c%0d", k, c), 32'(tx_done), 32'(c == 19));
        end else begin
          check($sformatf("burst f%0d gap txd", k), 32'(uart_txd), 32'd1);
          check($sformatf("burst f%0d gap busy", k), 32'(busy), 32'(k < 16));
        end
      end
      if (g == 16) check("burst ready at level 15", 32'(tx_ready), 32'd1);
      if (g == 17) begin
        check("burst ready at full", 32'(tx_ready), 32'd0);
        check("burst level full", 32'(fifo_level), 32'd16);
      end
      if (g == 18) check("burst level after drop", 32'(fifo_level), 32'd16);
      if (g < 18) begin
        tx_valid = 1'b1; tx_data = word(g);
      end else begin
        tx_valid = 1'b0;
      end
    end
    check("burst level drained", 32'(fifo_level), 32'd0);

    // Flush mid-frame with three words queued, coinciding with a push.
    repeat (3) @(negedge clk);
    for (int g = 0; g < 62; g++) begin
      @(negedge clk);
      if (g == 4) check("flush level before", 32'(fifo_level), 32'd3);
      if (g == 7) check("flush level after", 32'(fifo_level), 32'd0);
      if (g >= 2) begin
        int t;
        t = g - 2;
        if (t < 20) begin
          check($sformatf("flush txd c%0d", t), 32'(uart_txd),
                32'(exp_bit(word(100), 8, 1'b0, 1'b0, t, 2)));
          check($sformatf("flush tx_done c%0d", t), 32'(tx_done), 32'(t == 19));
        end else begin
          check($sformatf("flush after txd t%0d", t), 32'(uart_txd), 32'd1);
          check($sformatf("flush after tx_done t%0d", t), 32'(tx_done), 32'd0);
        end
        check($sformatf("flush busy t%0d", t), 32'(busy), 32'(t < 20));
      end
      flush = (g == 6);
      tx_valid = (g < 4) || (g == 6);
      tx_data = (g == 6) ? 8'hEE : word(100 + g);
    end
    flush = 1'b0; tx_valid = 1'b0;

    // Reset while a zero data bit is on the line.
    set_8n1(16'd4);
    @(negedge clk); tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("pre-reset txd data bit", 32'(uart_txd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset txd", 32'(uart_txd), 32'd1);
    check("async reset level", 32'(fifo_level), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post-reset quiet txd", 32'(uart_txd), 32'd1);
    end
    run_frame(vecs[0], "post-reset");

`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    set_8n1(16'd2);
    repeat (3) @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("cts held txd", 32'(uart_txd), 32'd1);
    end
    check("cts held level", 32'(fifo_level), 32'd1);
    cts_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("cts sync delay txd", 32'(uart_txd), 32'd1);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 4) cts_n = 1'b1;
      check($sformatf("cts txd c%0d", c), 32'(uart_txd),
            32'(exp_bit(8'h3C, 8, 1'b0, 1'b0, c, 2)));
    end
    @(negedge clk);
    check("cts idle busy", 32'(busy), 32'd0);
    cts_n = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
